// File: rtl/lif_hebbian_train_scheduler.sv
// Training/evaluation sequencer for a 3-input Hebbian LIF neuron.
// Ports: clk/reset, start, cfg_* table write, spike_in, rd_* count read, x*/learn_en/epoch/busy/done.
module lif_hebbian_train_scheduler #(
  parameter int NUM_PATTERNS   = 4,
  parameter int PRESENT_CYCLES = 50,
  parameter int REST_CYCLES    = 50,
  parameter int N_EPOCHS       = 3,
  parameter int CNT_W          = 8,
  localparam int IDX_W = $clog2(NUM_PATTERNS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [2:0]       cfg_pattern,
  input  logic             spike_in,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [CNT_W-1:0] rd_count,
  output logic             x0,
  output logic             x1,
  output logic             x2,
  output logic             learn_en,
  output logic [7:0]       epoch,
  output logic             busy,
  output logic             done
);

  localparam int MAXC  = (PRESENT_CYCLES > REST_CYCLES) ?
                         PRESENT_CYCLES : REST_CYCLES;
  localparam int CYC_W = $clog2(MAXC + 1);
  localparam logic [CYC_W-1:0] PRES_LAST =
    CYC_W'(PRESENT_CYCLES - 1);
  localparam logic [CYC_W-1:0] REST_LAST =
    CYC_W'((REST_CYCLES > 0) ? REST_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PATTERNS - 1);
  localparam logic [7:0] N_EP = 8'(N_EPOCHS);

  typedef enum logic [2:0] {
    IDLE, TR_PRES, TR_REST, EV_PRES, EV_REST, DONE
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CYC_W-1:0] cyc, cyc_n;
  logic [7:0]       epoch_q, epoch_n;
  logic [2:0]       x_q, x_n, pat_n;
  logic             learn_q, learn_n;
  logic             clr, step, training, wr_ok;
  logic [2:0]       pat_tab [NUM_PATTERNS];
  logic [CNT_W-1:0] cnt_q   [NUM_PATTERNS];

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cyc_n    = cyc;
    epoch_n  = epoch_q;
    clr      = 1'b0;
    step     = 1'b0;
    wr_ok    = cfg_we && (state == IDLE || state == DONE);
    training = (state == TR_PRES) || (state == TR_REST);
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = TR_PRES;
          idx_n   = '0;
          cyc_n   = '0;
          epoch_n = '0;
          clr     = 1'b1;
        end
      end
      TR_PRES, EV_PRES: begin
        if (cyc == PRES_LAST) begin
          cyc_n = '0;
          if (REST_CYCLES > 0)
            state_n = training ? TR_REST : EV_REST;
          else
            step = 1'b1;
        end else begin
          cyc_n = cyc + CYC_W'(1);
        end
      end
      TR_REST, EV_REST: begin
        if (cyc == REST_LAST) begin
          cyc_n = '0;
          step  = 1'b1;
        end else begin
          cyc_n = cyc + CYC_W'(1);
        end
      end
      default: ;
    endcase
    // end of one pattern's present+rest window
    if (step) begin
      if (idx != LAST) begin
        idx_n   = idx + IDX_W'(1);
        state_n = training ? TR_PRES : EV_PRES;
      end else begin
        idx_n = '0;
        if (training) begin
          epoch_n = epoch_q + 8'd1;
          state_n = (epoch_n == N_EP) ? EV_PRES : TR_PRES;
        end else begin
          state_n = DONE;
        end
      end
    end
    // a write in the start cycle must reach the first pattern
    pat_n = (wr_ok && cfg_addr == idx_n) ?
            cfg_pattern : pat_tab[idx_n];
    x_n = (state_n == TR_PRES || state_n == EV_PRES) ?
          pat_n : 3'b000;
    learn_n = (state_n == TR_PRES) || (state_n == TR_REST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      cyc     <= '0;
      epoch_q <= '0;
      x_q     <= '0;
      learn_q <= 1'b0;
      for (int i = 0; i < NUM_PATTERNS; i++) begin
        pat_tab[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cyc     <= cyc_n;
      epoch_q <= epoch_n;
      x_q     <= x_n;
      learn_q <= learn_n;
      if (wr_ok)
        pat_tab[cfg_addr] <= cfg_pattern;
      for (int i = 0; i < NUM_PATTERNS; i++) begin
        if (clr)
          cnt_q[i] <= '0;
        else if (state == EV_PRES && spike_in &&
                 idx == IDX_W'(i) && cnt_q[i] != '1)
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign rd_count = cnt_q[rd_addr];
  assign x0       = x_q[0];
  assign x1       = x_q[1];
  assign x2       = x_q[2];
  assign learn_en = learn_q;
  assign epoch    = epoch_q;
  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);

endmodule
